// File: rtl/qtest_onchip_mem_reader.sv
// Avalon-MM burst-less read master for the qtest on-chip RAM s2 port, streaming words out on Avalon-ST.
// Optional XOR checksum output is enabled by defining QTEST_MEM_READER_CHECKSUM_EN.
module qtest_onchip_mem_reader #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 64,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
`ifdef QTEST_MEM_READER_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  output logic                src_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]              state;
  logic [ADDR_W:0]         issue_left;
  logic [ADDR_W:0]         total;
  logic [ADDR_W:0]         xfer_count;
  logic [READ_LATENCY-1:0] valid_pipe;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           inflight;
  logic [CW:0]             credit_used;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    last_xfer;
  logic                    accept_start;
  logic                    done_r;

  assign m_write      = 1'b0;
  assign m_byteenable = '1;
  assign m_clken      = 1'b1;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      if (valid_pipe[i]) inflight = inflight + CW'(1);
    end
  end

  // Credit rule: a read is only issued when its data is guaranteed a FIFO slot.
  assign credit_used  = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue        = (state == ISSUE) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign m_chipselect = issue;

  assign push         = valid_pipe[READ_LATENCY-1];
  assign src_valid    = (fifo_count != '0);
  assign pop          = src_valid && src_ready;
  assign src_data     = src_valid ? fifo_mem[rd_ptr] : '0;
  assign src_last     = src_valid && (xfer_count == (total - (ADDR_W+1)'(1)));
  assign last_xfer    = pop && src_last;
  assign accept_start = (state == IDLE) && start;
  assign busy         = (state != IDLE);
  assign done         = done_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      issue_left <= '0;
      total      <= '0;
      xfer_count <= '0;
      m_address  <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_address  <= start_addr;
            issue_left <= word_count;
            total      <= word_count;
            xfer_count <= '0;
            if (word_count != '0) state  <= ISSUE;
            else                  done_r <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            m_address  <= m_address + ADDR_W'(1);
            issue_left <= issue_left - (ADDR_W+1)'(1);
            if (issue_left == (ADDR_W+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) xfer_count <= xfer_count + (ADDR_W+1)'(1);
    end
  end

  // Return path: one flag per outstanding read, aligned with the RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) valid_pipe[i] <= valid_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= m_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef QTEST_MEM_READER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)             checksum <= '0;
    else if (accept_start) checksum <= '0;
    else if (pop)          checksum <= checksum ^ src_data;
  end
`endif

  push_not_full: assert property (@(posedge clk) disable iff (reset)
    push |-> (fifo_count < CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_qtest_onchip_mem_reader.sv
// Self-checking bench for qtest_onchip_mem_reader: RAM model, stream scoreboard and randomized commands.
// Define QTEST_MEM_READER_CHECKSUM_EN to also check the checksum port.
module tb_qtest_onchip_mem_reader;

  localparam int ADDR_W       = 14;
  localparam int DATA_W       = 64;
  localparam int READ_LATENCY = 1;
  localparam int FIFO_DEPTH   = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W:0]     word_count;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   m_address;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;
  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready;
  logic                src_last;
`ifdef QTEST_MEM_READER_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum;
`endif

  qtest_onchip_mem_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .word_count(word_count),
    .busy(busy), .done(done), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_byteenable(m_byteenable), .m_clken(m_clken), .m_readdata(m_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
`ifdef QTEST_MEM_READER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .src_last(src_last)
  );

  always #5 clk = ~clk;

  // RAM model: address registered on the clock, output unregistered (latency 1).
  logic [DATA_W-1:0] ram [1 << ADDR_W];
  logic [ADDR_W-1:0] rd_addr_q = '0;
  always @(posedge clk) if (m_chipselect) rd_addr_q <= m_address;
  assign m_readdata = ram[rd_addr_q];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model state, advanced once per cycle by the monitor.
  logic [DATA_W-1:0] exp_q [$];
  bit                model_busy = 0;
  bit                done_pending = 0;
  logic [ADDR_W-1:0] exp_issue_addr = '0;
  int                issues_left = 0;
  int                outstanding = 0;
  int                xfers = 0;
  int                cyc = 0;
  int                start_cycle = 0;
  int                first_valid_cycle = -1;
  int                first_xfer_cycle = -1;
  int                last_xfer_cycle = -1;
  logic [DATA_W-1:0] chk_model = '0;
  logic [DATA_W-1:0] prev_data = '0;
  bit                prev_stall = 0;
  int                ready_mode = 0;

  always @(negedge clk) begin
    bit                done_now;
    bit                busy_next;
    logic [ADDR_W-1:0] a;
    cyc++;
    if (reset) begin
      exp_q.delete();
      model_busy   = 0;
      done_pending = 0;
      issues_left  = 0;
      outstanding  = 0;
      prev_stall   = 0;
    end else begin
      done_now     = done_pending;
      done_pending = 0;
      busy_next    = model_busy;
      checkOutput("busy", 64'(busy), 64'(model_busy));
      checkOutput("done", 64'(done), 64'(done_now));
`ifdef QTEST_MEM_READER_CHECKSUM_EN
      if (done_now) checkOutput("checksum", checksum, chk_model);
`endif
      if (!model_busy) begin
        checkOutput("idle_valid", 64'(src_valid), 64'(0));
        checkOutput("idle_chipselect", 64'(m_chipselect), 64'(0));
      end
      if (m_chipselect) begin
        checkOutput("issue_addr", 64'(m_address), 64'(exp_issue_addr));
        checkOutput("issue_allowed", 64'(issues_left > 0), 64'(1));
        exp_issue_addr = exp_issue_addr + 1'b1;
        if (issues_left > 0) issues_left--;
        outstanding++;
      end
      checkOutput("outstanding_le_depth", 64'(outstanding <= FIFO_DEPTH), 64'(1));
      if (prev_stall) begin
        checkOutput("stall_valid", 64'(src_valid), 64'(1));
        checkOutput("stall_data", src_data, prev_data);
      end
      if (src_valid) begin
        if (first_valid_cycle < 0) first_valid_cycle = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_valid", 64'(src_valid), 64'(0));
        end else begin
          checkOutput("src_data", src_data, exp_q[0]);
          checkOutput("src_last", 64'(src_last), 64'(exp_q.size() == 1));
          if (src_ready) begin
            chk_model = chk_model ^ exp_q.pop_front();
            outstanding--;
            xfers++;
            if (first_xfer_cycle < 0) first_xfer_cycle = cyc;
            last_xfer_cycle = cyc;
            if (exp_q.size() == 0) begin
              done_pending = 1;
              busy_next    = 0;
            end
          end
        end
      end else begin
        checkOutput("src_last_novalid", 64'(src_last), 64'(0));
      end
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      if (start && !model_busy) begin
        chk_model = '0;
        if (word_count == '0) begin
          done_pending = 1;
        end else begin
          busy_next         = 1;
          a                 = start_addr;
          for (int i = 0; i < int'(word_count); i++) begin
            exp_q.push_back(ram[a]);
            a = a + 1'b1;
          end
          exp_issue_addr    = start_addr;
          issues_left       = int'(word_count);
          xfers             = 0;
          start_cycle       = cyc + 1;
          first_valid_cycle = -1;
          first_xfer_cycle  = -1;
        end
      end
      model_busy = busy_next;
    end
  end

  initial begin
    int rcnt = 0;
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        default: src_ready = 1'($urandom_range(0, 1));
      endcase
      rcnt++;
    end
  end

  task automatic pulseStart(input logic [ADDR_W-1:0] addr, input int count);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = addr;
    word_count = (ADDR_W+1)'(count);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input int count);
    bit finished;
    pulseStart(addr, count);
    finished = 0;
    for (int i = 0; i < 3000 && !finished; i++) begin
      @(negedge clk);
      #1;
      finished = !model_busy && !done_pending;
    end
    checkOutput("command_finished", 64'(finished), 64'(1));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_cs"}, 64'(m_chipselect), 64'(0));
    checkOutput({tag, "_valid"}, 64'(src_valid), 64'(0));
    checkOutput({tag, "_last"}, 64'(src_last), 64'(0));
    checkOutput({tag, "_addr"}, 64'(m_address), 64'(0));
    checkOutput({tag, "_data"}, src_data, 64'(0));
  endtask

  initial begin
    bit reached;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 64'(i);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    checkOutput("m_write", 64'(m_write), 64'(0));
    checkOutput("m_byteenable", 64'(m_byteenable), 64'hff);
    checkOutput("m_clken", 64'(m_clken), 64'(1));

    ready_mode = 0;
    applyStimulus(14'd10, 4);
    checkOutput("first_valid_latency", 64'(first_valid_cycle - start_cycle), 64'(READ_LATENCY + 1));
    checkOutput("throughput_span", 64'(last_xfer_cycle - first_xfer_cycle), 64'(3));
    checkOutput("xfers_cmd2", 64'(xfers), 64'(4));

    applyStimulus(14'd16382, 3);

    ready_mode = 1;
    applyStimulus(14'd100, 16);
    checkOutput("xfers_backpressure", 64'(xfers), 64'(16));

    applyStimulus(14'd50, 0);

    // A second start during a running command must leave it untouched.
    fork
      applyStimulus(14'd200, 8);
      begin
        repeat (4) @(posedge clk);
        #2;
        start      = 1'b1;
        start_addr = 14'd5;
        word_count = 15'd3;
        @(posedge clk);
        #2 start = 1'b0;
      end
    join
    checkOutput("xfers_start_busy", 64'(xfers), 64'(8));

    ready_mode = 0;
    pulseStart(14'd0, 16);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      #1;
      reached = (xfers >= 5);
    end
    checkOutput("reached_5_words", 64'(reached), 64'(1));
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    checkResetOutputs("midreset");
    applyStimulus(14'd0, 2);
    checkOutput("xfers_after_reset", 64'(xfers), 64'(2));

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = {$urandom, $urandom};
    ready_mode = 2;
    for (int n = 0; n < 25; n++) begin
      logic [ADDR_W-1:0] addr;
      int                count;
      addr  = ADDR_W'($urandom);
      if (n % 5 == 0) addr = ADDR_W'((1 << ADDR_W) - $urandom_range(1, 4));
      count = (n % 7 == 3) ? 0 : int'($urandom_range(1, 40));
      applyStimulus(addr, count);
      checkOutput("xfers_random", 64'(xfers == count || count == 0), 64'(1));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
